// File: rtl/diamond_pkg.sv
// Shared types and constants for the diamond collection path (detectors and sprite controller).
package diamond_pkg;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    FADING  = 2'd1,
    GONE    = 2'd2
  } diamond_state_t;

  localparam int NUM_DIAMONDS = 3;
  localparam int SPRITE_SIZE  = 20;

  localparam int DIAMOND_X0 = 460;
  localparam int DIAMOND_Y0 = 408;
  localparam int DIAMOND_X1 = 366;
  localparam int DIAMOND_Y1 = 238;
  localparam int DIAMOND_X2 = 38;
  localparam int DIAMOND_Y2 = 90;

  localparam int DEFAULT_FADE_FRAMES = 16;

  // True when pos lies in the half-open span [lo, lo+len); 11 bits keep lo+len from wrapping.
  function automatic logic in_span(input logic [10:0] pos, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/diamond_fade_fsm.sv
// One diamond's lifecycle: visible until eaten, then a frame-timed fade, then gone until restart.
module diamond_fade_fsm
  import diamond_pkg::*;
#(
  parameter int FADE_FRAMES = DEFAULT_FADE_FRAMES
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           restart,
  input  logic           eat_i,
  input  logic           tick,
  output diamond_state_t state,
  output logic [1:0]     fade_level
);

  localparam int CW = $clog2(FADE_FRAMES);

  diamond_state_t  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= VISIBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // restart outranks both eat and tick; a tick coinciding with the eat is not counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = VISIBLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        VISIBLE: begin
          if (eat_i) begin
            state_d = FADING;
            cnt_d   = '0;
          end
        end
        FADING: begin
          if (tick) begin
            if (cnt_q == CW'(FADE_FRAMES - 1)) begin
              state_d = GONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        GONE:    state_d = GONE;
        default: begin
          state_d = VISIBLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign fade_level = (state_q == FADING) ? cnt_q[CW-1 -: 2] : 2'd0;

endmodule

// File: rtl/diamond_sprite_ctrl.sv
// Diamond pixel layer: frame tick detect, per-diamond fade FSMs, registered hit/address pipeline, all-collected flag.
module diamond_sprite_ctrl
  import diamond_pkg::*;
#(
  parameter int X0          = DIAMOND_X0,
  parameter int Y0          = DIAMOND_Y0,
  parameter int X1          = DIAMOND_X1,
  parameter int Y1          = DIAMOND_Y1,
  parameter int X2          = DIAMOND_X2,
  parameter int Y2          = DIAMOND_Y2,
  parameter int SIZE        = SPRITE_SIZE,
  parameter int FADE_FRAMES = DEFAULT_FADE_FRAMES
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    restart,
  input  logic [NUM_DIAMONDS-1:0] eat,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic                    is_diamond,
  output logic [1:0]              diamond_idx,
  output logic [8:0]              sprite_addr,
  output logic [1:0]              fade_level,
  output logic                    all_gone,
  output logic                    gone_pulse
);

  localparam logic [10:0] XS [NUM_DIAMONDS] = '{11'(X0), 11'(X1), 11'(X2)};
  localparam logic [10:0] YS [NUM_DIAMONDS] = '{11'(Y0), 11'(Y1), 11'(Y2)};
  localparam logic [10:0] SIZE_W = 11'(SIZE);

  logic frame_clk_q;
  logic tick;

  diamond_state_t          state [NUM_DIAMONDS];
  logic [1:0]              fade  [NUM_DIAMONDS];
  logic [8:0]              addr  [NUM_DIAMONDS];
  logic [NUM_DIAMONDS-1:0] hit;
  logic [NUM_DIAMONDS-1:0] gone;

  logic       is_diamond_q, is_diamond_d;
  logic [1:0] diamond_idx_q, diamond_idx_d;
  logic [8:0] sprite_addr_q, sprite_addr_d;
  logic [1:0] fade_level_q, fade_level_d;
  logic       all_gone_q, all_gone_d;
  logic       gone_pulse_q, gone_pulse_d;

  assign tick = frame_clk & ~frame_clk_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIAMONDS; gi++) begin : g_diamond
      diamond_fade_fsm #(
        .FADE_FRAMES (FADE_FRAMES)
      ) u_fsm (
        .Clk        (Clk),
        .Reset      (Reset),
        .restart    (restart),
        .eat_i      (eat[gi]),
        .tick       (tick),
        .state      (state[gi]),
        .fade_level (fade[gi])
      );

      assign gone[gi] = (state[gi] == GONE);
      assign hit[gi]  = in_span({1'b0, DrawX}, XS[gi], SIZE_W) &&
                        in_span({1'b0, DrawY}, YS[gi], SIZE_W) && !gone[gi];
      // Offsets are below SIZE whenever hit is set, so 9-bit modular arithmetic is exact.
      assign addr[gi] = (DrawY[8:0] - YS[gi][8:0]) * 9'(SIZE) + (DrawX[8:0] - XS[gi][8:0]);
    end
  endgenerate

  // Walk from the highest index down so the lowest overlapping diamond has the last word.
  always_comb begin
    is_diamond_d  = 1'b0;
    diamond_idx_d = 2'd0;
    sprite_addr_d = 9'd0;
    fade_level_d  = 2'd0;
    for (int i = NUM_DIAMONDS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        is_diamond_d  = 1'b1;
        diamond_idx_d = 2'(i);
        sprite_addr_d = addr[i];
        fade_level_d  = fade[i];
      end
    end
  end

  always_comb begin
    all_gone_d   = (&gone) & ~restart;
    gone_pulse_d = all_gone_d & ~all_gone_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_clk_q   <= 1'b0;
      is_diamond_q  <= 1'b0;
      diamond_idx_q <= 2'd0;
      sprite_addr_q <= 9'd0;
      fade_level_q  <= 2'd0;
      all_gone_q    <= 1'b0;
      gone_pulse_q  <= 1'b0;
    end else begin
      frame_clk_q   <= frame_clk;
      is_diamond_q  <= is_diamond_d;
      diamond_idx_q <= diamond_idx_d;
      sprite_addr_q <= sprite_addr_d;
      fade_level_q  <= fade_level_d;
      all_gone_q    <= all_gone_d;
      gone_pulse_q  <= gone_pulse_d;
    end
  end

  assign is_diamond  = is_diamond_q;
  assign diamond_idx = diamond_idx_q;
  assign sprite_addr = sprite_addr_q;
  assign fade_level  = fade_level_q;
  assign all_gone    = all_gone_q;
  assign gone_pulse  = gone_pulse_q;

endmodule
